// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - ID-to-EX handshake and ALU control bundle for alu_ctrl_seq
interface alu_ctrl_seq_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  ALUOp;
   logic [10:0] Opcode;
   logic        out_valid;
   logic [3:0]  ALUCnt;
   logic        illegal;
   logic        mc_busy;
   logic        mc_done;

   modport master (
      output flush, in_valid, ALUOp, Opcode,
      input  in_ready, out_valid, ALUCnt, illegal, mc_busy, mc_done
   );

   modport slave (
      input  flush, in_valid, ALUOp, Opcode,
      output in_ready, out_valid, ALUCnt, illegal, mc_busy, mc_done
   );
endinterface

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decode with MUL/UDIV latency sequencing
module alu_ctrl_seq #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 16,
   parameter int LAT_W   = 5
) (
   input  logic          clk,
   input  logic          rst,
   alu_ctrl_seq_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [LAT_W-1:0] MUL_LD = LAT_W'(MUL_LAT - 1);
   localparam logic [LAT_W-1:0] DIV_LD = LAT_W'(DIV_LAT - 1);

   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [3:0]       alu_cnt_q, alu_cnt_d;
   logic             illegal_q, illegal_d;

   logic             in_ready;
   logic             accept;
   logic [3:0]       dec_cnt;
   logic             dec_ill;
   logic             dec_mc;
   logic [LAT_W-1:0] dec_ld;

   // Undecodable encodings fall through to the 1111/illegal default.
   always_comb begin
      dec_cnt = 4'b1111;
      dec_ill = 1'b1;
      dec_mc  = 1'b0;
      dec_ld  = '0;
      case (bus.ALUOp)
         2'b00: begin dec_cnt = 4'b0010; dec_ill = 1'b0; end
         2'b01: begin dec_cnt = 4'b0111; dec_ill = 1'b0; end
         2'b10: begin
            case (bus.Opcode)
               11'b10001011000: begin dec_cnt = 4'b0010; dec_ill = 1'b0; end
               11'b11001011000: begin dec_cnt = 4'b0110; dec_ill = 1'b0; end
               11'b10001010000: begin dec_cnt = 4'b0000; dec_ill = 1'b0; end
               11'b10101010000: begin dec_cnt = 4'b0001; dec_ill = 1'b0; end
               11'b11001010000: begin dec_cnt = 4'b0011; dec_ill = 1'b0; end
               11'b11010011011: begin dec_cnt = 4'b1000; dec_ill = 1'b0; end
               11'b11010011010: begin dec_cnt = 4'b1001; dec_ill = 1'b0; end
               11'b10011011000: begin
                  dec_cnt = 4'b1010; dec_ill = 1'b0; dec_mc = 1'b1; dec_ld = MUL_LD;
               end
               11'b10011010110: begin
                  dec_cnt = 4'b1011; dec_ill = 1'b0; dec_mc = 1'b1; dec_ld = DIV_LD;
               end
               default: ;
            endcase
         end
         default: begin
            case (bus.Opcode[10:1])
               10'b1001000100: begin dec_cnt = 4'b0010; dec_ill = 1'b0; end
               10'b1101000100: begin dec_cnt = 4'b0110; dec_ill = 1'b0; end
               10'b1001001000: begin dec_cnt = 4'b0000; dec_ill = 1'b0; end
               10'b1011001000: begin dec_cnt = 4'b0001; dec_ill = 1'b0; end
               default: ;
            endcase
         end
      endcase
   end

   assign in_ready = (state_q == IDLE) && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = accept;
      alu_cnt_d   = alu_cnt_q;
      illegal_d   = illegal_q;
      if (accept) begin
         alu_cnt_d = dec_cnt;
         illegal_d = dec_ill;
      end
      case (state_q)
         IDLE: begin
            if (accept && dec_mc) begin
               state_d = BUSY;
               cnt_d   = dec_ld;
            end
         end
         default: begin
            // Counter is only loaded from IDLE and parks at 0, so it cannot wrap.
            if (bus.flush || cnt_q == '0) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         alu_cnt_q   <= 4'b0000;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         alu_cnt_q   <= alu_cnt_d;
         illegal_q   <= illegal_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.ALUCnt    = alu_cnt_q;
   assign bus.illegal   = illegal_q;
   assign bus.mc_busy   = (state_q == BUSY);
   assign bus.mc_done   = (state_q == BUSY) && (cnt_q == '0) && !bus.flush;

endmodule
